// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci generator/checker pair.
// Seeds match the generator's reset values.
package fib_pkg;

  localparam int FIB_WIDTH = 8;

  localparam logic [FIB_WIDTH-1:0] FIB_SEED_A = 8'd0;
  localparam logic [FIB_WIDTH-1:0] FIB_SEED_B = 8'd1;

  typedef enum logic [1:0] {
    SYNC0,
    SYNC1,
    CHECK
  } state_t;

endpackage

// File: rtl/fib_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fib_stream_checker.sv
// Receive-side checker for the Fibonacci byte stream.
// Locks onto the sequence and flags bytes that break it.
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int WIDTH    = FIB_WIDTH,
  parameter int CNT_W    = 16,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             hold,
  input  logic [WIDTH-1:0] data,
  output logic             locked,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [WIDTH-1:0] expect_val
);

  localparam logic [7:0] LOCK_V = 8'(LOCK_LEN);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev1, prev1_n;
  logic [WIDTH-1:0] prev2, prev2_n;
  logic [7:0]       run, run_n;
  logic             locked_n;
  logic             mismatch_n;
  logic [WIDTH-1:0] expect_n;

  logic [WIDTH-1:0] sum;
  logic             hold_ok;
  logic             adv_ok;
  logic             match_inc;
  logic             err_inc;

  assign sum     = prev1 + prev2;
  assign hold_ok = hold && (data == prev1);
  assign adv_ok  = !hold && (data == sum);

  assign match_inc = valid && (state == CHECK) && adv_ok;
  assign err_inc   = valid && (state == CHECK) && !hold_ok
                   && !adv_ok && locked;

  always_comb begin
    state_n    = state;
    prev1_n    = prev1;
    prev2_n    = prev2;
    run_n      = run;
    locked_n   = locked;
    mismatch_n = 1'b0;
    expect_n   = expect_val;
    if (valid) begin
      unique case (state)
        SYNC0: begin
          prev1_n = data;
          state_n = SYNC1;
        end
        SYNC1: begin
          prev1_n = data;
          if (!hold) begin
            prev2_n  = prev1;
            run_n    = 8'd0;
            state_n  = CHECK;
            expect_n = data + prev1;
          end
        end
        CHECK: begin
          unique case (1'b1)
            hold_ok: begin
            end
            adv_ok: begin
              prev2_n  = prev1;
              prev1_n  = data;
              run_n    = (run == LOCK_V) ? run : run + 8'd1;
              expect_n = data + prev1;
              if (run_n == LOCK_V) locked_n = 1'b1;
            end
            default: begin
              // resync from the offending byte
              mismatch_n = 1'b1;
              locked_n   = 1'b0;
              run_n      = 8'd0;
              prev1_n    = data;
              expect_n   = '0;
              state_n    = SYNC1;
            end
          endcase
        end
        default: begin
          state_n = SYNC0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC0;
      prev1      <= '0;
      prev2      <= '0;
      run        <= '0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      expect_val <= '0;
    end else begin
      state      <= state_n;
      prev1      <= prev1_n;
      prev2      <= prev2_n;
      run        <= run_n;
      locked     <= locked_n;
      mismatch   <= mismatch_n;
      expect_val <= expect_n;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (match_inc),
    .cnt (match_cnt)
  );

endmodule
